// File: rtl/core_db_ecc_dec.sv
// Hamming SEC decoder with a 1-deep valid/ready output register and saturating error counters.
// Define CORE_DB_SECDED_EN to add an overall even-parity bit (SECDED decoding).
`timescale 1ns/1ps

module core_db_ecc_dec #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16,
  localparam int P = (DATA_W <= 4)  ? 3 :
                     (DATA_W <= 11) ? 4 :
                     (DATA_W <= 26) ? 5 :
                     (DATA_W <= 57) ? 6 : 7,
  localparam int N = DATA_W + P,
`ifdef CORE_DB_SECDED_EN
  localparam int CODE_W = N + 1
`else
  localparam int CODE_W = N
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [P-1:0]      out_syndrome,
  output logic              out_sec,
  output logic              out_ded,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  sec_cnt,
  output logic [CNT_W-1:0]  ded_cnt
);

  // Syndrome is the XOR of the indices of every set code position.
  function automatic logic [P-1:0] calc_syn(input logic [N-1:0] c);
    logic [P-1:0] s;
    logic [N-1:0] t;
    s = '0;
    for (int i = 1; i <= N; i++) begin
      t = c >> (i - 1);
      if (t[0]) s = s ^ i[P-1:0];
    end
    return s;
  endfunction

  // Payload bits occupy the non-power-of-two positions, LSB at the lowest position.
  function automatic logic [DATA_W-1:0] extract(input logic [N-1:0] c);
    logic [DATA_W-1:0] d;
    logic [N-1:0]      t;
    d = '0;
    for (int i = 1; i <= N; i++) begin
      t = c >> (i - 1);
      if ((i & (i - 1)) != 0) d = {t[0], d[DATA_W-1:1]};
    end
    return d;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic              accept;
  logic [N-1:0]      word_p0;
  logic [N-1:0]      fix_p0;
  logic [P-1:0]      syn_p0;
  logic              in_range_p0;
  logic              sec_p0;
  logic              ded_p0;
  logic [DATA_W-1:0] data_p0;

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic [P-1:0]      syn_p1;
  logic              sec_p1;
  logic              ded_p1;
  logic [CNT_W-1:0]  sec_cnt_p1;
  logic [CNT_W-1:0]  ded_cnt_p1;

  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready;

  // Stage p0: combinational decode of the incoming codeword
  assign word_p0     = in_code[N-1:0];
  assign syn_p0      = calc_syn(word_p0);
  assign in_range_p0 = (syn_p0 != '0) && (int'(syn_p0) <= N);

  always_comb begin
    fix_p0 = word_p0;
    sec_p0 = 1'b0;
    ded_p0 = 1'b0;
`ifdef CORE_DB_SECDED_EN
    if (syn_p0 == '0) begin
      // Only the overall parity bit itself can be wrong here.
      sec_p0 = ^in_code;
    end else if ((^in_code) && in_range_p0) begin
      fix_p0 = word_p0 ^ ({{(N-1){1'b0}}, 1'b1} << (syn_p0 - 1'b1));
      sec_p0 = 1'b1;
    end else begin
      ded_p0 = 1'b1;
    end
`else
    if (syn_p0 != '0) begin
      if (in_range_p0) begin
        fix_p0 = word_p0 ^ ({{(N-1){1'b0}}, 1'b1} << (syn_p0 - 1'b1));
        sec_p0 = 1'b1;
      end else begin
        ded_p0 = 1'b1;
      end
    end
`endif
    data_p0 = extract(fix_p0);
  end

  // Stage p1: output holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      syn_p1  <= '0;
      sec_p1  <= 1'b0;
      ded_p1  <= 1'b0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      data_p1 <= data_p0;
      syn_p1  <= syn_p0;
      sec_p1  <= sec_p0;
      ded_p1  <= ded_p0;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt_p1 <= '0;
      ded_cnt_p1 <= '0;
    end else if (cnt_clr) begin
      sec_cnt_p1 <= '0;
      ded_cnt_p1 <= '0;
    end else if (accept) begin
      if (sec_p0) sec_cnt_p1 <= sat_inc(sec_cnt_p1);
      if (ded_p0) ded_cnt_p1 <= sat_inc(ded_cnt_p1);
    end
  end

  assign out_valid    = vld_p1;
  assign out_data     = data_p1;
  assign out_syndrome = syn_p1;
  assign out_sec      = sec_p1;
  assign out_ded      = ded_p1;
  assign sec_cnt      = sec_cnt_p1;
  assign ded_cnt      = ded_cnt_p1;

endmodule
